// File: rtl/td4_pkg.sv
// ============================================================================
//  Module   : td4_pkg
//  Purpose  : Shared types and constants for the TD4 4-bit CPU datapath.
//             Source-select encodings, load-strobe bit indices and the
//             4-bit machine word type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package td4_pkg;

  // Machine word: the ISA fixes every datapath value at 4 bits.
  typedef logic [3:0] td4_word_t;

  // Source-select encodings on {sel_b, sel_a}.
  typedef enum logic [1:0] {
    SRC_A    = 2'b00,
    SRC_B    = 2'b01,
    SRC_IN   = 2'b10,
    SRC_ZERO = 2'b11
  } td4_src_e;

  // Bit positions of the active-low load strobes within ld_n.
  localparam int LD_A   = 3;
  localparam int LD_B   = 2;
  localparam int LD_OUT = 1;
  localparam int LD_PC  = 0;

endpackage : td4_pkg

`default_nettype wire

// File: rtl/td4_reg4.sv
// ============================================================================
//  Module   : td4_reg4
//  Purpose  : 4-bit register with synchronous active-high reset, active-low
//             load strobe and clock enable. Used for A, B and OUT.
//  Ports    : clk   - system clock
//             rst   - synchronous active-high reset (beats en and ld_n)
//             en    - clock enable; hold when low
//             ld_n  - active-low load strobe
//             d     - data to load
//             q     - registered value
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module td4_reg4
  import td4_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      ld_n,
  input  td4_word_t d,
  output td4_word_t q
);

  td4_word_t data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en && !ld_n) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule : td4_reg4

`default_nettype wire

// File: rtl/td4_datapath.sv
// ============================================================================
//  Module   : td4_datapath
//  Purpose  : Registered TD4 datapath. Selects a source (A, B, input port or
//             zero), adds the instruction immediate and commits the sum to
//             any register whose load strobe is low. PC increments when not
//             loaded. Carry is updated from the adder every enabled edge.
//  Ports    : clk      - system clock
//             rst      - synchronous active-high reset
//             step     - clock enable (only when TD4_STEP_EN is defined)
//             sel_a    - source select LSB
//             sel_b    - source select MSB
//             ld_n     - active-low load strobes [3]=A [2]=B [1]=OUT [0]=PC
//             imm      - instruction immediate
//             in_port  - external input port
//             out_port - OUT register
//             pc       - program counter (ROM address)
//             carry    - registered carry flag, to decoder cin
//             reg_a    - A register
//             reg_b    - B register
//  Config   : TD4_STEP_EN - adds the step port; edges with step=0 hold all
//             state. Without it every edge is enabled.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module td4_datapath
  import td4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef TD4_STEP_EN
  input  logic       step,
`endif
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic [3:0] ld_n,
  input  logic [3:0] imm,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic [3:0] pc,
  output logic       carry,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b
);

  logic      w_en;
  td4_word_t w_src;
  td4_word_t w_sum;
  logic      w_co;
  td4_word_t pc_d;
  td4_word_t pc_q;
  logic      carry_q;

`ifdef TD4_STEP_EN
  assign w_en = step;
`else
  assign w_en = 1'b1;
`endif

  // Source mux
  always_comb begin
    w_src = '0;
    case (td4_src_e'({sel_b, sel_a}))
      SRC_A:    w_src = reg_a;
      SRC_B:    w_src = reg_b;
      SRC_IN:   w_src = in_port;
      SRC_ZERO: w_src = '0;
      default:  w_src = '0;
    endcase
  end

  // 5-bit add: bit 4 is the carry out.
  assign {w_co, w_sum} = {1'b0, w_src} + {1'b0, imm};

  // PC: load takes priority over increment; increment wraps silently.
  always_comb begin
    pc_d = pc_q + 4'd1;
    if (!ld_n[LD_PC]) begin
      pc_d = w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      carry_q <= 1'b0;
    end else if (w_en) begin
      pc_q    <= pc_d;
      carry_q <= w_co;
    end
  end

  td4_reg4 u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .ld_n (ld_n[LD_A]),
    .d    (w_sum),
    .q    (reg_a)
  );

  td4_reg4 u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .ld_n (ld_n[LD_B]),
    .d    (w_sum),
    .q    (reg_b)
  );

  td4_reg4 u_reg_out (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .ld_n (ld_n[LD_OUT]),
    .d    (w_sum),
    .q    (out_port)
  );

  assign pc    = pc_q;
  assign carry = carry_q;

endmodule : td4_datapath

`default_nettype wire

// File: tb/tb_td4_datapath.sv
// ============================================================================
//  Module   : tb_td4_datapath
//  Purpose  : Self-checking bench for td4_datapath. Directed vectors with
//             hand-computed register state after each edge are queued by the
//             driver; a monitor pops and compares after every rising edge.
//  Config   : TD4_STEP_EN - connects step and adds clock-enable vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_td4_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b1;
  logic       sel_a = 1'b1;
  logic       sel_b = 1'b1;
  logic [3:0] ld_n = 4'b1111;
  logic [3:0] imm = 4'h0;
  logic [3:0] in_port = 4'h0;
  logic [3:0] out_port;
  logic [3:0] pc;
  logic       carry;
  logic [3:0] reg_a;
  logic [3:0] reg_b;

  td4_datapath dut (
    .clk      (clk),
    .rst      (rst),
`ifdef TD4_STEP_EN
    .step     (step),
`endif
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .ld_n     (ld_n),
    .imm      (imm),
    .in_port  (in_port),
    .out_port (out_port),
    .pc       (pc),
    .carry    (carry),
    .reg_a    (reg_a),
    .reg_b    (reg_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;

  task automatic chk(input string name, input int id, input logic [3:0] act,
                     input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, req);
    end
  endtask

  // Monitor: state is presented after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",       e.id, pc,       e.pc);
      chk("reg_a",    e.id, reg_a,    e.a);
      chk("reg_b",    e.id, reg_b,    e.b);
      chk("out_port", e.id, out_port, e.o);
      chk("carry",    e.id, {3'b000, carry}, {3'b000, e.c});
    end
  end

  // Drive one instruction and queue the state expected after its edge.
  task automatic issue(input logic r, input logic s, input logic [1:0] sel,
                       input logic [3:0] ld, input logic [3:0] im,
                       input logic [3:0] inp,
                       input logic [3:0] epc, input logic [3:0] ea,
                       input logic [3:0] eb, input logic [3:0] eo,
                       input logic ec);
    exp_t e;
    @(negedge clk);
    rst     = r;
    step    = s;
    {sel_b, sel_a} = sel;
    ld_n    = ld;
    imm     = im;
    in_port = inp;
    e.id = vec_id;
    e.pc = epc; e.a = ea; e.b = eb; e.o = eo; e.c = ec;
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    //     rst step sel    ld_n     imm    in     pc     a      b      out    c
    issue(1, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0); // reset
    issue(0, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0); // fetch
    issue(0, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    issue(0, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 0);
    issue(0, 1, 2'b11, 4'b0111, 4'h9, 4'h0, 4'h4, 4'h9, 4'h0, 4'h0, 0); // MOV A,9
    issue(0, 1, 2'b00, 4'b0111, 4'h8, 4'h0, 4'h5, 4'h1, 4'h0, 4'h0, 1); // ADD A,8
    issue(0, 1, 2'b10, 4'b1011, 4'h0, 4'h5, 4'h6, 4'h1, 4'h5, 4'h0, 0); // IN B
    issue(0, 1, 2'b01, 4'b1101, 4'h0, 4'h0, 4'h7, 4'h1, 4'h5, 4'h5, 0); // OUT B
    issue(0, 1, 2'b11, 4'b1110, 4'h6, 4'h0, 4'h6, 4'h1, 4'h5, 4'h5, 0); // JMP 6
    issue(0, 1, 2'b11, 4'b1110, 4'h3, 4'h0, 4'h3, 4'h1, 4'h5, 4'h5, 0); // JMP 3
    issue(0, 1, 2'b11, 4'b1110, 4'hF, 4'h0, 4'hF, 4'h1, 4'h5, 4'h5, 0); // JMP 15
    issue(0, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h1, 4'h5, 4'h5, 0); // wrap
    issue(0, 1, 2'b11, 4'b0111, 4'hF, 4'h0, 4'h1, 4'hF, 4'h5, 4'h5, 0); // MOV A,15
    issue(0, 1, 2'b00, 4'b0111, 4'h1, 4'h0, 4'h2, 4'h0, 4'h5, 4'h5, 1); // ADD A,1
    issue(0, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h3, 4'h0, 4'h5, 4'h5, 0); // carry clr
    issue(0, 1, 2'b01, 4'b1111, 4'hC, 4'h0, 4'h4, 4'h0, 4'h5, 4'h5, 1); // carry, no load
    issue(0, 1, 2'b10, 4'b0000, 4'h4, 4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 0); // all load
    issue(0, 1, 2'b10, 4'b1101, 4'hF, 4'hF, 4'h8, 4'h7, 4'h7, 4'hE, 1); // in+imm ovf
    issue(1, 1, 2'b11, 4'b0000, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0); // mid reset
    issue(0, 1, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
`ifdef TD4_STEP_EN
    issue(0, 0, 2'b11, 4'b0111, 4'h7, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0); // stalled
    issue(0, 0, 2'b11, 4'b0111, 4'h7, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
    issue(0, 0, 2'b11, 4'b0111, 4'h7, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
    issue(0, 1, 2'b11, 4'b0111, 4'h7, 4'h0, 4'h2, 4'h7, 4'h0, 4'h0, 0); // stepped
    issue(0, 1, 2'b00, 4'b1101, 4'hA, 4'h0, 4'h3, 4'h7, 4'h0, 4'h1, 1); // carry set
    issue(1, 0, 2'b11, 4'b0000, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0); // rst, step=0
    issue(0, 0, 2'b11, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
`endif
    @(negedge clk);
    rst  = 1'b0;
    ld_n = 4'b1111;
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

endmodule : tb_td4_datapath

`default_nettype wire
